// File: rtl/mem_arbiter_2stage.sv
// Two-port memory arbiter: shares one variable-latency memory port between
// the core's fetch and data ports, one transaction at a time, with a watchdog.
module mem_arbiter_2stage #(
  parameter int unsigned STREAK_MAX = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_imem_req_valid,
  input  logic [31:0] io_imem_req_bits_addr,
  output logic        io_imem_resp_valid,
  output logic [31:0] io_imem_resp_bits_data,
  input  logic        io_dmem_req_valid,
  input  logic [31:0] io_dmem_req_bits_addr,
  input  logic [31:0] io_dmem_req_bits_data,
  input  logic        io_dmem_req_bits_fcn,
  input  logic [2:0]  io_dmem_req_bits_typ,
  output logic        io_dmem_resp_valid,
  output logic [31:0] io_dmem_resp_bits_data,
  output logic        io_mem_req_valid,
  input  logic        io_mem_req_ready,
  output logic [31:0] io_mem_req_bits_addr,
  output logic [31:0] io_mem_req_bits_data,
  output logic        io_mem_req_bits_fcn,
  output logic [2:0]  io_mem_req_bits_typ,
  input  logic        io_mem_resp_valid,
  input  logic [31:0] io_mem_resp_bits_data,
  output logic        io_busy,
  output logic        io_timeout
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2, S_RESP = 2'd3} state_t;

  localparam int unsigned   SW         = $clog2(STREAK_MAX + 2);
  localparam logic [SW-1:0] STREAK_LIM = SW'(STREAK_MAX);
  localparam logic [15:0]   WDOG_LAST  = 16'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic [SW-1:0] streak_q, streak_d;
  logic [15:0]   wdog_q, wdog_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          fcn_q, fcn_d;
  logic [2:0]    typ_q, typ_d;
  logic          req_valid_q, req_valid_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          imem_rv_q, imem_rv_d;
  logic          dmem_rv_q, dmem_rv_d;
  logic          timeout_q, timeout_d;
  logic          busy_q, busy_d;
  logic          grant_dmem;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    streak_d    = streak_q;
    wdog_d      = wdog_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    fcn_d       = fcn_q;
    typ_d       = typ_q;
    req_valid_d = req_valid_q;
    rdata_d     = rdata_q;
    imem_rv_d   = 1'b0;
    dmem_rv_d   = 1'b0;
    timeout_d   = 1'b0;
    grant_dmem  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (io_imem_req_valid || io_dmem_req_valid) begin
          // dmem wins unless it has starved a waiting fetch for STREAK_MAX grants
          grant_dmem  = io_dmem_req_valid && !(io_imem_req_valid && streak_q == STREAK_LIM);
          state_d     = S_REQ;
          req_valid_d = 1'b1;
          if (grant_dmem) begin
            owner_d  = 1'b1;
            addr_d   = io_dmem_req_bits_addr;
            wdata_d  = io_dmem_req_bits_data;
            fcn_d    = io_dmem_req_bits_fcn;
            typ_d    = io_dmem_req_bits_typ;
            if (!io_imem_req_valid)       streak_d = '0;
            else if (streak_q != STREAK_LIM) streak_d = streak_q + SW'(1);
          end else begin
            owner_d  = 1'b0;
            addr_d   = io_imem_req_bits_addr;
            wdata_d  = '0;
            fcn_d    = 1'b0;
            typ_d    = 3'd3;
            streak_d = '0;
          end
        end
      end
      S_REQ: begin
        if (io_mem_req_ready) begin
          state_d     = S_WAIT;
          req_valid_d = 1'b0;
          wdog_d      = '0;
        end
      end
      S_WAIT: begin
        wdog_d = wdog_q + 16'd1;
        // a real response takes precedence over a simultaneous watchdog expiry
        if (io_mem_resp_valid) begin
          rdata_d   = io_mem_resp_bits_data;
          state_d   = S_RESP;
          imem_rv_d = !owner_q;
          dmem_rv_d = owner_q;
        end else if (wdog_q == WDOG_LAST) begin
          rdata_d   = '0;
          timeout_d = 1'b1;
          state_d   = S_RESP;
          imem_rv_d = !owner_q;
          dmem_rv_d = owner_q;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      owner_q     <= 1'b0;
      streak_q    <= '0;
      wdog_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      fcn_q       <= 1'b0;
      typ_q       <= '0;
      req_valid_q <= 1'b0;
      rdata_q     <= '0;
      imem_rv_q   <= 1'b0;
      dmem_rv_q   <= 1'b0;
      timeout_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      streak_q    <= streak_d;
      wdog_q      <= wdog_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      fcn_q       <= fcn_d;
      typ_q       <= typ_d;
      req_valid_q <= req_valid_d;
      rdata_q     <= rdata_d;
      imem_rv_q   <= imem_rv_d;
      dmem_rv_q   <= dmem_rv_d;
      timeout_q   <= timeout_d;
      busy_q      <= busy_d;
    end
  end

  assign io_mem_req_valid       = req_valid_q;
  assign io_mem_req_bits_addr   = addr_q;
  assign io_mem_req_bits_data   = wdata_q;
  assign io_mem_req_bits_fcn    = fcn_q;
  assign io_mem_req_bits_typ    = typ_q;
  assign io_imem_resp_valid     = imem_rv_q;
  assign io_dmem_resp_valid     = dmem_rv_q;
  assign io_imem_resp_bits_data = rdata_q;
  assign io_dmem_resp_bits_data = rdata_q;
  assign io_busy                = busy_q;
  assign io_timeout             = timeout_q;

endmodule

// File: tb/tb_mem_arbiter_2stage.sv
// Directed bench for mem_arbiter_2stage: fetch, streak fairness, stalled store,
// watchdog expiry, response at the expiry cycle and mid-transaction reset.
module tb_mem_arbiter_2stage;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        imem_valid = 1'b0;
  logic [31:0] imem_addr = '0;
  logic        imem_rv;
  logic [31:0] imem_rdata;
  logic        dmem_valid = 1'b0;
  logic [31:0] dmem_addr = '0;
  logic [31:0] dmem_wdata = '0;
  logic        dmem_fcn = 1'b0;
  logic [2:0]  dmem_typ = '0;
  logic        dmem_rv;
  logic [31:0] dmem_rdata;
  logic        mem_req_valid;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_fcn;
  logic [2:0]  mem_typ;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_data = '0;
  logic        busy;
  logic        timeout;

  int errors = 0;
  int checks = 0;

  mem_arbiter_2stage #(.STREAK_MAX(4), .TIMEOUT(8)) dut (
    .clock                  (clock),
    .reset                  (reset),
    .io_imem_req_valid      (imem_valid),
    .io_imem_req_bits_addr  (imem_addr),
    .io_imem_resp_valid     (imem_rv),
    .io_imem_resp_bits_data (imem_rdata),
    .io_dmem_req_valid      (dmem_valid),
    .io_dmem_req_bits_addr  (dmem_addr),
    .io_dmem_req_bits_data  (dmem_wdata),
    .io_dmem_req_bits_fcn   (dmem_fcn),
    .io_dmem_req_bits_typ   (dmem_typ),
    .io_dmem_resp_valid     (dmem_rv),
    .io_dmem_resp_bits_data (dmem_rdata),
    .io_mem_req_valid       (mem_req_valid),
    .io_mem_req_ready       (mem_ready),
    .io_mem_req_bits_addr   (mem_addr),
    .io_mem_req_bits_data   (mem_wdata),
    .io_mem_req_bits_fcn    (mem_fcn),
    .io_mem_req_bits_typ    (mem_typ),
    .io_mem_resp_valid      (mem_resp_valid),
    .io_mem_resp_bits_data  (mem_resp_data),
    .io_busy                (busy),
    .io_timeout             (timeout)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 100000");
    $fatal(1);
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mem_req_valid) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h1234_5678;
    step();
    checks++;
    if ({busy, mem_req_valid, imem_rv, dmem_rv, timeout} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 00000", {busy, mem_req_valid, imem_rv, dmem_rv, timeout});
    end
    checks++;
    if ({mem_addr, mem_wdata, mem_fcn, mem_typ} !== 68'h0) begin
      errors++;
      $display("FAIL reset_req_fields: got %h required 0", {mem_addr, mem_wdata, mem_fcn, mem_typ});
    end
    checks++;
    if ({imem_rdata, dmem_rdata} !== 64'h0) begin
      errors++;
      $display("FAIL reset_resp_data: got %h required 0", {imem_rdata, dmem_rdata});
    end
    mem_resp_valid = 1'b0;
    reset = 1'b1;
    step();
    checks++;
    if ({busy, imem_rv, dmem_rv} !== 3'b000) begin
      errors++;
      $display("FAIL reset_release_idle: got %b required 000", {busy, imem_rv, dmem_rv});
    end
  endtask

  task automatic test_lone_fetch();
    imem_valid = 1'b1;
    imem_addr  = 32'h8000_0000;
    mem_ready  = 1'b1;
    step();
    checks++;
    if ({mem_req_valid, mem_fcn, mem_typ, mem_addr, busy} !== {1'b1, 1'b0, 3'd3, 32'h8000_0000, 1'b1}) begin
      errors++;
      $display("FAIL fetch_req: got v=%b fcn=%b typ=%0d addr=%h busy=%b required v=1 fcn=0 typ=3 addr=80000000 busy=1",
               mem_req_valid, mem_fcn, mem_typ, mem_addr, busy);
    end
    step();
    checks++;
    if ({mem_req_valid, imem_rv, dmem_rv} !== 3'b000) begin
      errors++;
      $display("FAIL fetch_wait: got %b required 000", {mem_req_valid, imem_rv, dmem_rv});
    end
    step();
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h0000_0013;
    step();
    checks++;
    if ({imem_rv, dmem_rv, imem_rdata} !== {1'b1, 1'b0, 32'h0000_0013}) begin
      errors++;
      $display("FAIL fetch_resp: got irv=%b drv=%b data=%h required irv=1 drv=0 data=00000013",
               imem_rv, dmem_rv, imem_rdata);
    end
    mem_resp_valid = 1'b0;
    imem_valid     = 1'b0;
    step();
    checks++;
    if ({imem_rv, dmem_rv, busy} !== 3'b000) begin
      errors++;
      $display("FAIL fetch_done: got %b required 000", {imem_rv, dmem_rv, busy});
    end
  endtask

  task automatic test_streak();
    bit ok;
    bit exp_d [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] exp_addr;
    imem_valid = 1'b1;
    imem_addr  = 32'h0000_1000;
    dmem_valid = 1'b1;
    dmem_addr  = 32'h0000_2000;
    dmem_wdata = 32'h0;
    dmem_fcn   = 1'b0;
    dmem_typ   = 3'd2;
    mem_ready  = 1'b1;
    for (int k = 0; k < 10; k++) begin
      exp_addr = exp_d[k] ? 32'h0000_2000 : 32'h0000_1000;
      wait_req(ok);
      checks++;
      if (!ok || mem_addr !== exp_addr) begin
        errors++;
        $display("FAIL streak_grant_%0d: got ok=%b addr=%h required addr=%h", k, ok, mem_addr, exp_addr);
      end
      step();
      mem_resp_valid = 1'b1;
      mem_resp_data  = 32'(k);
      step();
      checks++;
      if ({imem_rv, dmem_rv} !== (exp_d[k] ? 2'b01 : 2'b10)) begin
        errors++;
        $display("FAIL streak_resp_%0d: got irv/drv=%b required %b", k, {imem_rv, dmem_rv},
                 exp_d[k] ? 2'b01 : 2'b10);
      end
      mem_resp_valid = 1'b0;
    end
    imem_valid = 1'b0;
    dmem_valid = 1'b0;
    step();
    step();
  endtask

  task automatic test_store_stall();
    dmem_valid = 1'b1;
    dmem_addr  = 32'h0000_0100;
    dmem_wdata = 32'hDEAD_BEEF;
    dmem_fcn   = 1'b1;
    dmem_typ   = 3'd2;
    mem_ready  = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({mem_req_valid, mem_addr, mem_wdata, mem_fcn, mem_typ} !==
          {1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 1'b1, 3'd2}) begin
        errors++;
        $display("FAIL store_stall_%0d: got v=%b addr=%h data=%h fcn=%b typ=%0d required v=1 addr=00000100 data=deadbeef fcn=1 typ=2",
                 i, mem_req_valid, mem_addr, mem_wdata, mem_fcn, mem_typ);
      end
      step();
    end
    mem_ready = 1'b1;
    step();
    checks++;
    if (mem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL store_single_handshake: got valid=%b required 0", mem_req_valid);
    end
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h55AA_55AA;
    step();
    checks++;
    if ({imem_rv, dmem_rv, dmem_rdata} !== {1'b0, 1'b1, 32'h55AA_55AA}) begin
      errors++;
      $display("FAIL store_ack: got irv=%b drv=%b data=%h required irv=0 drv=1 data=55aa55aa",
               imem_rv, dmem_rv, dmem_rdata);
    end
    mem_resp_valid = 1'b0;
    dmem_valid     = 1'b0;
    step();
  endtask

  task automatic test_timeout();
    dmem_valid = 1'b1;
    dmem_addr  = 32'h0000_0200;
    dmem_fcn   = 1'b0;
    dmem_typ   = 3'd2;
    mem_ready  = 1'b1;
    step();
    step();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({timeout, busy, dmem_rv} !== 3'b010) begin
        errors++;
        $display("FAIL timeout_wait_%0d: got to/busy/drv=%b required 010", i, {timeout, busy, dmem_rv});
      end
      if (i < 7) step();
    end
    step();
    checks++;
    if ({timeout, dmem_rv, imem_rv, dmem_rdata} !== {1'b1, 1'b1, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL timeout_fire: got to=%b drv=%b irv=%b data=%h required to=1 drv=1 irv=0 data=00000000",
               timeout, dmem_rv, imem_rv, dmem_rdata);
    end
    dmem_valid = 1'b0;
    step();
    checks++;
    if ({timeout, busy, dmem_rv} !== 3'b000) begin
      errors++;
      $display("FAIL timeout_idle: got to/busy/drv=%b required 000", {timeout, busy, dmem_rv});
    end
  endtask

  task automatic test_resp_at_limit();
    imem_valid = 1'b1;
    imem_addr  = 32'h0000_0300;
    mem_ready  = 1'b1;
    step();
    step();
    for (int i = 0; i < 7; i++) step();
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'hCAFE_F00D;
    step();
    checks++;
    if ({timeout, imem_rv, dmem_rv, imem_rdata} !== {1'b0, 1'b1, 1'b0, 32'hCAFE_F00D}) begin
      errors++;
      $display("FAIL resp_at_limit: got to=%b irv=%b drv=%b data=%h required to=0 irv=1 drv=0 data=cafef00d",
               timeout, imem_rv, dmem_rv, imem_rdata);
    end
    mem_resp_valid = 1'b0;
    imem_valid     = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    dmem_valid = 1'b1;
    dmem_addr  = 32'h0000_0400;
    dmem_fcn   = 1'b0;
    dmem_typ   = 3'd2;
    mem_ready  = 1'b1;
    step();
    step();
    step();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL midreset_busy_before: got %b required 1", busy);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({busy, mem_req_valid, imem_rv, dmem_rv, timeout, mem_addr, dmem_rdata} !== 69'h0) begin
      errors++;
      $display("FAIL midreset_outputs: got busy=%b v=%b irv=%b drv=%b to=%b addr=%h data=%h required all 0",
               busy, mem_req_valid, imem_rv, dmem_rv, timeout, mem_addr, dmem_rdata);
    end
    dmem_valid = 1'b0;
    step();
    reset          = 1'b1;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h0000_0077;
    step();
    mem_resp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({imem_rv, dmem_rv, timeout, busy} !== 4'b0000) begin
        errors++;
        $display("FAIL midreset_late_resp_%0d: got irv/drv/to/busy=%b required 0000", i,
                 {imem_rv, dmem_rv, timeout, busy});
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_lone_fetch();
    test_streak();
    test_store_stall();
    test_timeout();
    test_resp_at_limit();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
